// File: rtl/tlight_pkg.sv
// Shared types and default timings for the multi-approach junction controller.
package tlight_pkg;

   typedef enum logic [2:0] {CLR, RA, G, A, WALK} phase_e;

   typedef struct packed {
      logic r;
      logic a;
      logic g;
   } lamp_t;

   localparam int DEF_NUM_DIR = 2;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_T_CLR   = 1;
   localparam int DEF_T_RA    = 2;
   localparam int DEF_T_G     = 4;
   localparam int DEF_T_A     = 2;
   localparam int DEF_T_WALK  = 3;

   // Lamp pattern of the served approach; WALK keeps every approach at red.
   function automatic lamp_t served_lamp(input phase_e ph);
      lamp_t l;
      l = '{r: 1'b1, a: 1'b0, g: 1'b0};
      case (ph)
         RA:      l = '{r: 1'b1, a: 1'b1, g: 1'b0};
         G:       l = '{r: 1'b0, a: 1'b0, g: 1'b1};
         A:       l = '{r: 1'b0, a: 1'b1, g: 1'b0};
         default: l = '{r: 1'b1, a: 1'b0, g: 1'b0};
      endcase
      return l;
   endfunction

endpackage

// File: rtl/tlight_junction_timer.sv
// Loadable phase down-counter; done flags the tick on which the count is already zero.
module tlight_timer #(
   parameter int               CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= RST_VAL;
      else if (load)
         count <= load_val;
      else if (tick && (count != '0))
         count <= count - CNT_W'(1);
   end

   assign done = tick && (count == '0);

endmodule

// File: rtl/tlight_junction.sv
// Round-robin UK-sequence junction controller with all-red clearance and a
// latched pedestrian request that inserts an all-red walk phase.
module tlight_junction
   import tlight_pkg::*;
#(
   parameter int NUM_DIR = DEF_NUM_DIR,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int T_CLR   = DEF_T_CLR,
   parameter int T_RA    = DEF_T_RA,
   parameter int T_G     = DEF_T_G,
   parameter int T_A     = DEF_T_A,
   parameter int T_WALK  = DEF_T_WALK
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic                       ped_req,
   output logic [NUM_DIR-1:0]         r,
   output logic [NUM_DIR-1:0]         a,
   output logic [NUM_DIR-1:0]         g,
   output logic                       walk,
   output logic                       ped_wait,
   output logic [$clog2(NUM_DIR)-1:0] cur_dir
);

   localparam int DIR_W = $clog2(NUM_DIR);

   if (NUM_DIR < 2 || T_CLR < 1 || T_RA < 1 || T_G < 1 || T_A < 1 || T_WALK < 1 ||
       T_CLR >= 2**CNT_W || T_RA >= 2**CNT_W || T_G >= 2**CNT_W ||
       T_A >= 2**CNT_W || T_WALK >= 2**CNT_W) begin : g_bad_param
      $error("tlight_junction: illegal NUM_DIR or phase duration parameters");
   end

   phase_e           phase, phase_nxt;
   logic [DIR_W-1:0] dir, dir_nxt;
   logic             ped_pending, ped_nxt;
   logic             walk_done, walk_done_nxt;
   logic             timer_done;
   logic [CNT_W-1:0] load_val;
   lamp_t            lamp;

   function automatic logic [CNT_W-1:0] phase_len(input phase_e ph);
      case (ph)
         CLR:     return CNT_W'(T_CLR - 1);
         RA:      return CNT_W'(T_RA - 1);
         G:       return CNT_W'(T_G - 1);
         A:       return CNT_W'(T_A - 1);
         WALK:    return CNT_W'(T_WALK - 1);
         default: return CNT_W'(T_CLR - 1);
      endcase
   endfunction

   tlight_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (CNT_W'(T_CLR - 1))
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .load     (timer_done),
      .load_val (load_val),
      .done     (timer_done)
   );

   always_comb begin
      phase_nxt     = phase;
      dir_nxt       = dir;
      walk_done_nxt = walk_done;
      ped_nxt       = ped_pending | ped_req;
      if (timer_done) begin
         case (phase)
            CLR: begin
               // A request served once must let traffic through before the next walk.
               if (ped_pending && !walk_done) begin
                  phase_nxt = WALK;
                  ped_nxt   = 1'b0;
               end else begin
                  phase_nxt     = RA;
                  walk_done_nxt = 1'b0;
               end
            end
            RA: phase_nxt = G;
            G:  phase_nxt = A;
            A: begin
               phase_nxt = CLR;
               dir_nxt   = (dir == DIR_W'(NUM_DIR - 1)) ? '0 : dir + DIR_W'(1);
            end
            WALK: begin
               phase_nxt     = CLR;
               walk_done_nxt = 1'b1;
            end
            default: phase_nxt = CLR;
         endcase
      end
      load_val = phase_len(phase_nxt);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase       <= CLR;
         dir         <= '0;
         ped_pending <= 1'b0;
         walk_done   <= 1'b0;
      end else begin
         if (tick) begin
            phase     <= phase_nxt;
            dir       <= dir_nxt;
            walk_done <= walk_done_nxt;
         end
         ped_pending <= ped_nxt;
      end
   end

   always_comb begin
      lamp     = served_lamp(phase);
      r        = '1;
      a        = '0;
      g        = '0;
      r[dir]   = lamp.r;
      a[dir]   = lamp.a;
      g[dir]   = lamp.g;
      walk     = (phase == WALK);
      ped_wait = ped_pending;
      cur_dir  = dir;
   end

   a_single_moving: assert property (@(posedge clk) disable iff (!rst) $onehot0(g | a));
   a_no_green_walk: assert property (@(posedge clk) disable iff (!rst) !(walk && (|g)));

endmodule

// File: doc/tlight_junction.md
Name: tlight_junction

Overview:
Parametrised successor to the single-approach traffic light controller. Drives NUM_DIR approaches round-robin through the UK sequence: red → red+amber → green → amber → red. Adds per-phase durations, an all-red clearance interval, a tick enable for prescaled operation, and a latched pedestrian request that inserts an all-red walk phase. Sits at junction top level; one instance per junction.

Parameters:
NUM_DIR, 2, number of approaches served round-robin (≥2)
CNT_W, 8, phase timer width
T_CLR, 1, all-red clearance length in ticks (≥1)
T_RA, 2, red+amber length in ticks (≥1)
T_G, 4, green length in ticks (≥1)
T_A, 2, amber length in ticks (≥1)
T_WALK, 3, pedestrian walk length in ticks (≥1); every T_* < 2**CNT_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
tick  in  1  timer enable; the phase timer advances only in cycles where tick=1
ped_req  in  1  pedestrian button, level, sampled every clk
r  out  NUM_DIR  red lamp per approach
a  out  NUM_DIR  amber lamp per approach
g  out  NUM_DIR  green lamp per approach
walk  out  1  pedestrian walk lamp
ped_wait  out  1  request latched, not yet served
cur_dir  out  $clog2(NUM_DIR)  approach currently served

Behaviour:
- Phases: CLR, RA, G, A, WALK. Registers: phase, dir, timer, ped_pending, walk_done.
- Moore outputs, decoded from registers only:
  - non-served approaches are always r=1, a=0, g=0.
  - served approach (dir):
    - CLR: r=1
    - RA: r=1, a=1
    - G: g=1
    - A: a=1
  - WALK: all approaches r=1; walk=1.
  - ped_wait = ped_pending; cur_dir = dir.
- Reset (rst=0, asynchronous):
  - phase=CLR, dir=0, timer=T_CLR-1, ped_pending=0, walk_done=0.
  - Hence r = all ones, a=0, g=0, walk=0, ped_wait=0, cur_dir=0.
- Timer:
  - On phase entry, load T_x-1.
  - On a tick=1 cycle: if timer≠0, decrement; if timer==0, take the transition (phase lasts exactly T_x ticks).
  - tick=0: all state holds, but ped_req is still latched.
- Transitions (at expiry):
  - CLR → WALK if ped_pending=1 and walk_done=0.
  - CLR → RA otherwise; clear walk_done.
  - RA → G.
  - G → A.
  - A → CLR; dir ← dir+1, wrapping NUM_DIR-1 → 0.
  - WALK → CLR; set walk_done=1, so the next CLR always proceeds to RA. This prevents pedestrian starvation of traffic.
- ped_pending:
  - Set when ped_req=1.
  - Cleared on the cycle of the CLR→WALK transition.
  - ped_req=1 on that same cycle is absorbed (pending ends 0).
  - ped_req during WALK re-latches; it is served after at least one full approach cycle.
- Safety invariant: never more than one approach with (g|a)=1, and never g=1 while walk=1. RTL carries assertions for both.
- With tick=1 continuously and no ped_req:
  - per-approach period = T_CLR+T_RA+T_G+T_A (9 at defaults).
  - full rotation = NUM_DIR × that (18).
- Reset mid-phase returns immediately to the reset state; any latched request is dropped.
- Elaboration-time $error if any T_* = 0, any T_* ≥ 2**CNT_W, or NUM_DIR < 2.

Decomposition:
- Package tlight_pkg: phase_e enum (CLR, RA, G, A, WALK) and a lamp struct {r, a, g}. Default-duration localparams are shared with the bench.
- One natural sub-module, tlight_timer: loadable CNT_W down-counter with load, load_val, tick, done (done = timer==0 & tick).
- The top holds the FSM, dir counter, pedestrian latch and output decode.

Test Plan:
1. Reset, default params, tick=1, no ped_req → cycle-exact sequence:
   - dir0: CLR 1 cycle, RA 2, G 4, A 2.
   - then dir1 with the same timings.
   - period 18; dir1 r=1 throughout dir0's phases.
2. tick asserted every 3rd clk → every phase duration ×3 (e.g. G lasts 12 clks); outputs stable between ticks.
3. ped_req pulse 1 clk during dir0 G → ped_wait=1 until the CLR after dir0 A expires, then WALK for 3 cycles (walk=1, r all 1). Next comes CLR, then RA on dir1; ped_wait=0 from the WALK entry.
4. ped_req held high continuously → WALK occurs once per approach (after each CLR, alternating with traffic), never two WALKs back-to-back; the RA/G/A of every approach still occurs.
5. Assert rst low mid-G of dir1, asynchronously between clk edges → outputs go immediately to r=all 1, walk=0, ped_wait=0, cur_dir=0. After release, the sequence restarts from CLR on dir0.
6. NUM_DIR=4, T_G=1, T_CLR=3 → dir wraps 3→0. G lasts exactly 1 cycle; the safety assertions hold for 1000 random ped_req/tick cycles.
